uart_tx_param: RTL
==================

// Module: uart_tx_param
// PURPOSE
//  Parametrised UART transmitter; successor to the fixed 8N1 transmitter.
//  Serialises a DBIT-wide word LSB-first: start bit, data, optional parity, stop.
//  Has an internal baud-tick divider, configurable oversampling and stop length.
//  Sits between the host/FIFO write side and the tx pin of the UART top.
// PARAMETERS
//  DBIT        8   data bits per frame (5..9)
//  DIV         1   clk cycles per oversample tick (>=1)
//  OVS         16  ticks per bit period (>=2)
//  SB_TICK     16  ticks in stop period (16=1, 24=1.5, 32=2 stop bits at OVS=16)
//  PARITY_ODD  0   0=even, 1=odd parity (used only with UART_TX_PARITY_EN)
// PORTS
//  clk       in   1     system clock, all logic on rising edge
//  reset     in   1     synchronous, active-high reset
//  d_in      in   DBIT  word to send, sampled when tx_start is accepted
//  tx_start  in   1     request; accepted only in IDLE
//  tx        out  1     serial line, idle high
//  tx_busy   out  1     high from the cycle after acceptance until back in IDLE
//  tx_done   out  1     one-cycle pulse on the last clk of the stop period
// BEHAVIOUR
//  Reset: state=IDLE, tx=1, tx_busy=0, tx_done=0; divider, tick, bit counters=0;
//   shift reg=0. Reset mid-frame aborts it: tx=1 on the next cycle, no tx_done.
//  Tick: divider counts 0..DIV-1 and emits a tick when at DIV-1; it is cleared on
//   acceptance, so every bit lasts exactly DIV*OVS clks, stop lasts DIV*SB_TICK.
//  FSM (registered tx, no combinational path from inputs to tx):
//   IDLE  : tx=1. tx_start=1 -> latch d_in into shift reg, go START.
//   START : tx=0 for OVS ticks -> DATA, bit counter n=0.
//   DATA  : tx=shreg[0] for OVS ticks, then shift right, n++; after bit
//           n=DBIT-1 -> PARITY (macro on) or STOP.
//   PARITY: tx=^word ^ PARITY_ODD for OVS ticks -> STOP.
//   STOP  : tx=1 for SB_TICK ticks; on final tick tx_done=1, -> IDLE.
//  Latency: tx falls on the first clk edge after the accepting edge.
//  tx_start while busy: ignored, not queued. tx_start held high: next frame is
//   accepted on the first cycle back in IDLE (cycle after tx_done), no extra idle.
//  d_in changes after acceptance have no effect on the frame in flight.
//  Frame length = (1+DBIT+P)*OVS*DIV + SB_TICK*DIV clks, P=1 if parity enabled.
//  Tick counter width clog2(max(OVS,SB_TICK)); bit counter width clog2(DBIT).
// CONFIGURATION
//  UART_TX_PARITY_EN defined: PARITY state present; parity over the latched word,
//   even when PARITY_ODD=0, odd when 1.
//  UART_TX_PARITY_EN undefined: PARITY state and logic absent, DATA -> STOP
//   directly; PARITY_ODD ignored.
// TESTING
//  1 reset: assert reset 2 clks -> tx=1, tx_busy=0, tx_done=0; with no tx_start
//    for 200 clks the outputs stay there.
//  2 8N1, DIV=1 OVS=16 SB_TICK=16, d_in=8'h55, tx_start 1 clk -> tx low 16 clks,
//    then 1,0,1,0,1,0,1,0 each 16 clks, high 16 clks, tx_done pulses exactly once
//    at clk 160 after acceptance, tx_busy low the next cycle.
//  3 parity (macro on, PARITY_ODD=0), d_in=8'h07 -> parity bit=1 for 16 clks
//    before stop; PARITY_ODD=1 -> 0; frame 176 clks.
//  4 busy/back-to-back: tx_start held high, d_in=8'hA3 then 8'h3C changed mid
//    frame -> first frame sends A3 intact, second frame (3C) starts the cycle
//    after tx_done; no idle gap, no dropped or duplicated frame.
//  5 generic: DBIT=7 DIV=4 SB_TICK=32, d_in=7'h41 -> each bit 64 clks, stop
//    128 clks, tx_done at clk 640 after acceptance.
//  6 reset mid-operation: reset during bit 3 of a frame -> tx=1, IDLE next cycle,
//    no tx_done; a subsequent tx_start sends a complete correct frame.

Source files
------------

// File: rtl/uart_tx_param.sv
// Parametrised UART transmitter: start bit, DBIT data bits LSB-first, optional parity, stop period.
// Parity bit and PARITY state are built only when UART_TX_PARITY_EN is defined.
module uart_tx_param #(
    parameter int unsigned DBIT       = 8,
    parameter int unsigned DIV        = 1,
    parameter int unsigned OVS        = 16,
    parameter int unsigned SB_TICK    = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [DBIT-1:0] d_in,
    input  logic            tx_start,
    output logic            tx,
    output logic            tx_busy,
    output logic            tx_done
);

    localparam int unsigned TICK_MAX = (OVS > SB_TICK) ? OVS : SB_TICK;
    localparam int unsigned TW       = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
    localparam int unsigned BW       = (DBIT > 1) ? $clog2(DBIT) : 1;
    localparam int unsigned DW       = (DIV > 1) ? $clog2(DIV) : 1;

    // Reject configurations outside the supported range at elaboration.
    if (DBIT < 5 || DBIT > 9 || DIV < 1 || OVS < 2 || SB_TICK < 1 || PARITY_ODD > 1) begin : g_bad_param
        $error("uart_tx_param: unsupported parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
`ifdef UART_TX_PARITY_EN
        S_PARITY,
`endif
        S_STOP
    } state_t;

    state_t          r_state;
    state_t          w_state_nx;
    logic [DW-1:0]   r_div;
    logic [DW-1:0]   w_div_nx;
    logic [TW-1:0]   r_cnt;
    logic [TW-1:0]   w_cnt_nx;
    logic [BW-1:0]   r_nbit;
    logic [BW-1:0]   w_nbit_nx;
    logic [DBIT-1:0] r_shreg;
    logic [DBIT-1:0] w_shreg_nx;
    logic            r_tx;
    logic            w_tx_nx;
    logic            r_busy;
    logic            w_busy_nx;
    logic            r_done;
    logic            w_done_nx;
    logic            w_tick;
`ifdef UART_TX_PARITY_EN
    logic            r_par;
    logic            w_par_nx;
`endif

    assign w_tick  = (r_div == DW'(DIV - 1));
    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

    // State, counters and registered line outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_div   <= '0;
            r_cnt   <= '0;
            r_nbit  <= '0;
            r_shreg <= '0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_par   <= 1'b0;
`endif
        end else begin
            r_state <= w_state_nx;
            r_div   <= w_div_nx;
            r_cnt   <= w_cnt_nx;
            r_nbit  <= w_nbit_nx;
            r_shreg <= w_shreg_nx;
            r_tx    <= w_tx_nx;
            r_busy  <= w_busy_nx;
            r_done  <= w_done_nx;
`ifdef UART_TX_PARITY_EN
            r_par   <= w_par_nx;
`endif
        end
    end

    // Next-state and output decode; line outputs follow the current state one clk later.
    always_comb begin
        w_state_nx = r_state;
        w_div_nx   = w_tick ? '0 : r_div + DW'(1);
        w_cnt_nx   = r_cnt;
        w_nbit_nx  = r_nbit;
        w_shreg_nx = r_shreg;
        w_tx_nx    = 1'b1;
        w_busy_nx  = (r_state != S_IDLE);
        w_done_nx  = 1'b0;
`ifdef UART_TX_PARITY_EN
        w_par_nx   = r_par;
`endif
        case (r_state)
            S_IDLE: begin
                w_div_nx  = '0;
                w_cnt_nx  = '0;
                w_nbit_nx = '0;
                if (tx_start) begin
                    w_state_nx = S_START;
                    w_shreg_nx = d_in;
`ifdef UART_TX_PARITY_EN
                    w_par_nx   = (^d_in) ^ 1'(PARITY_ODD);
`endif
                end
            end
            S_START: begin
                w_tx_nx = 1'b0;
                if (w_tick) begin
                    if (r_cnt == TW'(OVS - 1)) begin
                        w_cnt_nx   = '0;
                        w_nbit_nx  = '0;
                        w_state_nx = S_DATA;
                    end else begin
                        w_cnt_nx = r_cnt + TW'(1);
                    end
                end
            end
            S_DATA: begin
                w_tx_nx = r_shreg[0];
                if (w_tick) begin
                    if (r_cnt == TW'(OVS - 1)) begin
                        w_cnt_nx   = '0;
                        w_shreg_nx = {1'b0, r_shreg[DBIT-1:1]};
                        if (r_nbit == BW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
                            w_state_nx = S_PARITY;
`else
                            w_state_nx = S_STOP;
`endif
                        end else begin
                            w_nbit_nx = r_nbit + BW'(1);
                        end
                    end else begin
                        w_cnt_nx = r_cnt + TW'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                w_tx_nx = r_par;
                if (w_tick) begin
                    if (r_cnt == TW'(OVS - 1)) begin
                        w_cnt_nx   = '0;
                        w_state_nx = S_STOP;
                    end else begin
                        w_cnt_nx = r_cnt + TW'(1);
                    end
                end
            end
`endif
            S_STOP: begin
                w_tx_nx = 1'b1;
                if (w_tick) begin
                    if (r_cnt == TW'(SB_TICK - 1)) begin
                        w_cnt_nx   = '0;
                        w_done_nx  = 1'b1;
                        w_state_nx = S_IDLE;
                    end else begin
                        w_cnt_nx = r_cnt + TW'(1);
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
            end
        endcase
    end

endmodule
